correlation_peak: RTL

- Downstream consumer of the correlation stage: scans the finished correlation array and reports the peak value, its index and the signed lag relative to zero-lag.
- Started by the correlator's finished flag; the top-level FSM reads lag/done to drive the direction/delay decision.
- One element examined per clock; no multipliers.

---
 rtl/correlation_peak.sv | 135 +++++++++++++
 1 files changed

// File: rtl/correlation_peak.sv
// Scans a finished correlation array one sample per clock and reports
// the signed peak value, its index and its lag relative to zero-lag.
module correlation_peak #(
    parameter int N_RESULT = 3999,
    parameter int CENTER   = 1999,
    parameter int IW       = $clog2(N_RESULT)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [N_RESULT-1:0][7:0] result,
    output logic [7:0]               peak_val,
    output logic [IW-1:0]            peak_idx,
    output logic [IW:0]              lag,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N_RESULT - 1);
    localparam logic [IW:0]   CTR  = (IW+1)'(CENTER);

    state_t        state_q, state_d;
    logic [7:0]    best_val_q, best_val_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    peak_val_q, peak_val_d;
    logic [IW-1:0] peak_idx_q, peak_idx_d;
    logic [IW:0]   lag_q, lag_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    cand;
    logic          take;
    logic [7:0]    win_val;
    logic [IW-1:0] win_idx;

    always_comb begin
        state_d    = state_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        idx_d      = idx_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;
        lag_d      = lag_q;
        busy_d     = busy_q;
        done_d     = done_q;

        // Strictly-greater update keeps the lowest index on ties
        cand    = result[idx_q];
        take    = $signed(cand) > $signed(best_val_q);
        win_val = take ? cand : best_val_q;
        win_idx = take ? idx_q : best_idx_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    best_val_d = result[0];
                    best_idx_d = '0;
                    idx_d      = IW'(1);
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (!start) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == LAST) begin
                    peak_val_d = win_val;
                    peak_idx_d = win_idx;
                    lag_d      = {1'b0, win_idx} - CTR;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    best_val_d = win_val;
                    best_idx_d = win_idx;
                    idx_d      = idx_q + IW'(1);
                end
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            best_val_q <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
            lag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
            lag_q      <= lag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign peak_val = peak_val_q;
    assign peak_idx = peak_idx_q;
    assign lag      = lag_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
